// File: rtl/audio_sample_unpacker.sv
// rtl/audio_sample_unpacker.sv - HDMI audio sample packet to stereo sample FIFO unpacker
// Build option HDMI_AUDIO_PARITY_CHECK_EN zeroes channels failing IEC 60958 parity and raises parity_error.
module audio_sample_unpacker #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                            clk_audio,
  input  logic                            audio_buffer_rst,
  input  logic                            packet_valid,
  output logic                            packet_ready,
  input  logic [23:0]                     header,
  input  logic [3:0][55:0]                sub,
  input  logic                            sample_tick,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  output logic                            audio_sample_valid,
  output logic                            frame_start,
  output logic                            underrun,
  output logic                            parity_error
);
  localparam int W  = AUDIO_BIT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * W + 1;

  typedef enum logic {IDLE, UNPACK} state_t;

  state_t               state, state_next;
  logic                 rst_done;
  logic [1:0]           k;
  logic [3:0]           lat_present, lat_b;
  logic [3:0][W-1:0]    lat_left, lat_right;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic [EW-1:0]        head;
  logic                 accept, accept_t2, push, pop;
  logic                 unused_fields;

  assign unused_fields = ^{header, sub};

  // rst_done keeps the block closed until the first edge after reset release
  assign packet_ready = rst_done && (state == IDLE) && (count <= CW'(FIFO_DEPTH - 4));
  assign accept       = packet_valid && packet_ready;
  assign accept_t2    = accept && (header[7:0] == 8'h02);
  assign push         = (state == UNPACK) && lat_present[k];
  assign pop          = sample_tick && (count != '0);
  assign head         = mem[rptr];

`ifdef HDMI_AUDIO_PARITY_CHECK_EN
  logic [3:0] left_bad, right_bad, lat_bad;

  always_comb begin
    left_bad  = '0;
    right_bad = '0;
    for (int i = 0; i < 4; i++) begin
      left_bad[i]  = (^{sub[i][23:0],  sub[i][50:48]}) != sub[i][51];
      right_bad[i] = (^{sub[i][47:24], sub[i][54:52]}) != sub[i][55];
    end
  end

  always_ff @(posedge clk_audio) begin
    if (accept_t2) begin
      for (int i = 0; i < 4; i++) begin
        lat_left[i]  <= left_bad[i]  ? '0 : sub[i][W-1:0];
        lat_right[i] <= right_bad[i] ? '0 : sub[i][24+W-1:24];
        lat_bad[i]   <= left_bad[i] | right_bad[i];
      end
    end
  end

  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst)
      parity_error <= 1'b0;
    else if (push && lat_bad[k])
      parity_error <= 1'b1;
  end
`else
  always_ff @(posedge clk_audio) begin
    if (accept_t2) begin
      for (int i = 0; i < 4; i++) begin
        lat_left[i]  <= sub[i][W-1:0];
        lat_right[i] <= sub[i][24+W-1:24];
      end
    end
  end

  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk_audio) begin
    if (accept_t2) begin
      lat_present <= header[11:8];
      lat_b       <= header[23:20];
    end
  end

  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      state    <= IDLE;
      k        <= 2'd0;
      rst_done <= 1'b0;
    end else begin
      state    <= state_next;
      rst_done <= 1'b1;
      k        <= (state == UNPACK) ? k + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_t2) state_next = UNPACK;
      UNPACK:  if (k == 2'd3) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_audio) begin
    if (push)
      mem[wptr] <= {lat_left[k], lat_right[k], lat_b[k]};
  end

  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // An empty-FIFO tick never sees a same-cycle push: no bypass path
  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      audio_sample_word  <= '0;
      audio_sample_valid <= 1'b0;
      frame_start        <= 1'b0;
      underrun           <= 1'b0;
    end else begin
      audio_sample_valid <= pop;
      frame_start        <= pop && head[0];
      if (pop) begin
        audio_sample_word[0] <= head[EW-1:W+1];
        audio_sample_word[1] <= head[W:1];
      end
      if (sample_tick && (count == '0))
        underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_sample_unpacker.sv
// tb/tb_audio_sample_unpacker.sv - directed plus randomized bench for audio_sample_unpacker
// Optional HDMI_AUDIO_PARITY_CHECK_EN adds the parity scenario and parity-aware model.
module tb_audio_sample_unpacker;
  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic                 clk_audio = 1'b0;
  logic                 audio_buffer_rst = 1'b1;
  logic                 packet_valid = 1'b0;
  logic                 sample_tick = 1'b0;
  logic                 packet_ready;
  logic [23:0]          header = '0;
  logic [3:0][55:0]     sub = '0;
  logic [1:0][W-1:0]    audio_sample_word;
  logic                 audio_sample_valid, frame_start, underrun, parity_error;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic         b;
  } entry_t;

  entry_t       mq[$];
  logic [W-1:0] last_l = '0, last_r = '0;
  logic         uf_exp = 1'b0, pe_exp = 1'b0;
  int           n_cmp = 0, n_bad = 0;

  audio_sample_unpacker #(.AUDIO_BIT_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_audio(clk_audio),
    .audio_buffer_rst(audio_buffer_rst),
    .packet_valid(packet_valid),
    .packet_ready(packet_ready),
    .header(header),
    .sub(sub),
    .sample_tick(sample_tick),
    .audio_sample_word(audio_sample_word),
    .audio_sample_valid(audio_sample_valid),
    .frame_start(frame_start),
    .underrun(underrun),
    .parity_error(parity_error)
  );

  always #5 clk_audio = ~clk_audio;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_audio);
    @(negedge clk_audio);
  endtask

  function automatic logic [55:0] mk(input logic [23:0] l, input logic [23:0] r);
    logic [7:0] sb6;
    sb6    = '0;
    sb6[3] = ^l;
    sb6[7] = ^r;
    return {sb6, r, l};
  endfunction

  // One tick; the model pops if it holds data, otherwise the tick is an underrun.
  task automatic tick_check();
    entry_t e;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      check("valid", audio_sample_valid, 1'b1);
      check("left", audio_sample_word[0], e.l);
      check("right", audio_sample_word[1], e.r);
      check("frame_start", frame_start, e.b);
      last_l = e.l;
      last_r = e.r;
    end else begin
      uf_exp = 1'b1;
      check("valid_empty", audio_sample_valid, 1'b0);
      check("left_hold", audio_sample_word[0], last_l);
      check("right_hold", audio_sample_word[1], last_r);
      check("frame_start_empty", frame_start, 1'b0);
    end
    check("underrun", underrun, uf_exp);
  endtask

  task automatic tick();
    tick_check();
    check("ready_post_tick", packet_ready, mq.size() <= DEPTH - 4);
    cyc();
    check("valid_pulse", audio_sample_valid, 1'b0);
    check("frame_start_pulse", frame_start, 1'b0);
    check("parity_error", parity_error, pe_exp);
  endtask

  task automatic send(input logic [23:0] h, input logic [3:0][55:0] s, input bit tick_mid);
    entry_t e;
    entry_t add[$];
    int n = 0;
    logic pe_new = 1'b0;
    header = h;
    sub = s;
    packet_valid = 1'b1;
    while (!packet_ready && n < 50) begin
      cyc();
      n++;
    end
    check("ready_wait", n < 50, 1'b1);
    cyc();
    packet_valid = 1'b0;
    if (h[7:0] == 8'h02) begin
      for (int i = 0; i < 4; i++) begin
        if (h[8+i]) begin
          e.l = s[i][W-1:0];
          e.r = s[i][24+W-1:24];
          e.b = h[20+i];
`ifdef HDMI_AUDIO_PARITY_CHECK_EN
          if ((^s[i][23:0]) ^ (^s[i][51:48])) begin
            e.l = '0;
            pe_new = 1'b1;
          end
          if ((^s[i][47:24]) ^ (^s[i][55:52])) begin
            e.r = '0;
            pe_new = 1'b1;
          end
`endif
          add.push_back(e);
        end
      end
      if (tick_mid) begin
        tick_check();
        repeat (3) cyc();
      end else begin
        repeat (4) cyc();
      end
      foreach (add[i]) mq.push_back(add[i]);
      pe_exp = pe_exp | pe_new;
    end else begin
      check("discard_ready", packet_ready, 1'b1);
    end
    check("ready_after", packet_ready, mq.size() <= DEPTH - 4);
  endtask

  initial begin
    logic [3:0][55:0] s;
    logic [23:0]      h;

    @(negedge clk_audio);
    cyc();
    check("rst_ready", packet_ready, 1'b0);
    check("rst_valid", audio_sample_valid, 1'b0);
    check("rst_word", audio_sample_word, '0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_parity_error", parity_error, 1'b0);
    audio_buffer_rst = 1'b0;
    check("ready_at_release", packet_ready, 1'b0);
    cyc();
    check("ready_after_release", packet_ready, 1'b1);
    tick();
    tick();

    s = '0;
    s[0] = mk(24'h001234, 24'h005678);
    s[1] = mk(24'h00AAAA, 24'h005555);
    send({8'h00, 8'h03, 8'h02}, s, 1'b0);
    tick();
    tick();

    s[0] = mk(24'($urandom), 24'($urandom));
    s[1] = mk(24'($urandom), 24'($urandom));
    send({8'h10, 8'h03, 8'h02}, s, 1'b0);
    tick();
    tick();
    send({8'h00, 8'h0F, 8'h84}, s, 1'b0);
    tick();

    for (int i = 0; i < 4; i++) s[i] = mk(24'($urandom), 24'($urandom));
    send({8'hF0, 8'h0F, 8'h02}, s, 1'b0);
    send({8'h00, 8'h01, 8'h02}, s, 1'b0);
    tick();
    while (mq.size() > 0) tick();

    // pop of an older entry in the same cycle as a push
    send({8'h00, 8'h01, 8'h02}, s, 1'b0);
    s[0] = mk(24'h00BEEF, 24'h00CAFE);
    send({8'h10, 8'h01, 8'h02}, s, 1'b1);
    tick();
    tick();

`ifdef HDMI_AUDIO_PARITY_CHECK_EN
    s[0] = mk(24'h000F0F, 24'h003C3C);
    s[0][51] = ~s[0][51];
    send({8'h00, 8'h01, 8'h02}, s, 1'b0);
    tick();
    check("parity_left_zero", audio_sample_word[0], '0);
    check("parity_right_kept", audio_sample_word[1], 16'h3C3C);
    check("parity_flag", parity_error, 1'b1);
`endif

    header = {8'h00, 8'h0F, 8'h02};
    packet_valid = 1'b1;
    check("ready_before_abort", packet_ready, 1'b1);
    cyc();
    packet_valid = 1'b0;
    cyc();
    audio_buffer_rst = 1'b1;
    #1;
    check("abort_ready", packet_ready, 1'b0);
    check("abort_valid", audio_sample_valid, 1'b0);
    check("abort_word", audio_sample_word, '0);
    check("abort_underrun", underrun, 1'b0);
    check("abort_parity_error", parity_error, 1'b0);
    cyc();
    audio_buffer_rst = 1'b0;
    check("abort_ready_release", packet_ready, 1'b0);
    cyc();
    check("abort_ready_back", packet_ready, 1'b1);
    mq.delete();
    last_l = '0;
    last_r = '0;
    uf_exp = 1'b0;
    pe_exp = 1'b0;
    tick();
    tick();

    repeat (25) begin
      h = 24'($urandom);
      if ($urandom_range(0, 4) != 0) h[7:0] = 8'h02;
      for (int i = 0; i < 4; i++) s[i] = 56'({$urandom, $urandom});
      while (mq.size() > DEPTH - 4) tick();
      send(h, s, $urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    while (mq.size() > 0) tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_sample_unpacker.md
AUDIO_SAMPLE_UNPACKER -- requirements
Module: audio_sample_unpacker

Interface
REQ-001 Parameter AUDIO_BIT_WIDTH, default 16, sample width per channel (16..24).
REQ-002 Parameter FIFO_DEPTH, default 8, stereo-sample FIFO depth; power of two, minimum 4.
REQ-003 clk_audio  input  1  audio clock; all logic is synchronous to it.
REQ-004 audio_buffer_rst  input  1  reset; asynchronous, active-high.
REQ-005 packet_valid  input  1  a packet is presented on header/sub.
REQ-006 packet_ready  output  1  the block accepts the presented packet.
REQ-007 header  input  24  packet header; HB0=[7:0], HB1=[15:8], HB2=[23:16].
REQ-008 sub  input  4x56  subpackets 0..3; SB0=[7:0] .. SB6=[55:48].
REQ-009 sample_tick  input  1  request one stereo sample this cycle.
REQ-010 audio_sample_word  output  2xAUDIO_BIT_WIDTH  [0]=left, [1]=right.
REQ-011 audio_sample_valid  output  1  audio_sample_word updated this cycle.
REQ-012 frame_start  output  1  the current sample carries the IEC 60958 block-start (B) flag.
REQ-013 underrun  output  1  sticky flag: a tick arrived while the FIFO was empty.
REQ-014 parity_error  output  1  sticky flag: a channel failed the parity check.

Function
REQ-015 Handshake: a packet transfers when packet_valid and packet_ready are both high on a clk_audio edge.
REQ-016 packet_ready is high only in IDLE with at least 4 free FIFO entries.
REQ-017 Packets with HB0 != 8'h02 are accepted and discarded, with no FIFO or flag effect.
REQ-018 Sample-present bit k is HB1[k]; the B flag for subpacket k is HB2[4+k].
REQ-019 Left sample = sub[k][AUDIO_BIT_WIDTH-1:0]; right sample = sub[k][24+AUDIO_BIT_WIDTH-1:24]; upper pad bits are ignored.
REQ-020 FSM has two states, IDLE and UNPACK; an accepted type-2 packet is latched and moves the FSM to UNPACK with k=0.
REQ-021 In UNPACK, one subpacket k is examined per cycle, k=0..3; present subpackets write one FIFO entry {left, right, B}; absent ones write nothing.
REQ-022 After k=3 the FSM returns to IDLE; a 4-subpacket packet occupies exactly 4 cycles.
REQ-023 A type-2 packet with HB1[3:0]=0 still occupies 4 UNPACK cycles and writes nothing.
REQ-024 Pop: on a sample_tick edge with the FIFO non-empty, the head entry drives audio_sample_word, audio_sample_valid and frame_start on the next cycle (latency 1).
REQ-025 audio_sample_valid and frame_start are single-cycle pulses.
REQ-026 audio_sample_word holds its last value between pops.
REQ-027 Empty tick: sample_tick with the FIFO empty sets underrun, holds audio_sample_word, and keeps audio_sample_valid low.
REQ-028 A simultaneous push and pop in the same cycle are both performed; the occupancy count is unchanged.
REQ-029 A tick on an empty FIFO while a push occurs in the same cycle counts as underrun; the pushed entry is not bypassed.
REQ-030 FIFO read/write pointers wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-031 Overflow cannot occur, because REQ-016 guarantees free space before acceptance.
REQ-032 underrun and parity_error clear only on reset.

Reset
REQ-033 Asserting audio_buffer_rst immediately forces the FSM to IDLE and clears the FIFO pointers and count.
REQ-034 Asserting audio_buffer_rst clears audio_sample_word to 0, and clears audio_sample_valid, frame_start, underrun and parity_error to 0.
REQ-035 Asserting audio_buffer_rst forces packet_ready to 0.
REQ-036 Reset in UNPACK abandons the packet; entries already written are discarded.
REQ-037 packet_ready returns high on the first clk_audio edge after reset deasserts.

Configuration
REQ-038 Macro HDMI_AUDIO_PARITY_CHECK_EN, when defined: left parity = XOR(24-bit left field, SB6[0], SB6[1], SB6[2]) compared with SB6[3]; right parity = XOR(24-bit right field, SB6[4], SB6[5], SB6[6]) compared with SB6[7].
REQ-039 With the macro defined, a mismatching channel is written to the FIFO as 0 and parity_error is set.
REQ-040 With the macro undefined, no parity check is performed, samples pass unchanged, and parity_error is tied to 0.

Verification
REQ-041 Reset then idle: packet_ready=1, all outputs 0; ticks on the empty FIFO -> underrun=1, audio_sample_valid stays 0.
REQ-042 Type-2 packet, HB1=8'h03, sub0 L=16'h1234 R=16'h5678, sub1 L=16'hAAAA R=16'h5555, then two ticks -> two valid pulses, one cycle after each tick, with those words in order.
REQ-043 HB2=8'h10 -> frame_start=1 with sample 0 only; HB0=8'h84 packet -> no FIFO change and packet_ready=1 on the next cycle.
REQ-044 Fill 5 entries with FIFO_DEPTH=8 -> packet_ready=0; a tick frees an entry -> packet_ready=1 one cycle later.
REQ-045 audio_buffer_rst asserted in the second UNPACK cycle -> FIFO empty, ticks produce no valid pulse.
REQ-046 With HDMI_AUDIO_PARITY_CHECK_EN defined, a corrupted SB6[3] -> left output 0, right intact, parity_error=1.
